io_panel_arbiter: RTL and testbench

IO_PANEL_ARBITER -- requirements
Module: io_panel_arbiter

---
 rtl/io_panel_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_io_panel_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_panel_arbiter.sv
// io_panel_arbiter
//
// Arbitrates writes into four shared 32-bit panel registers between a host
// port and a local pushbutton/switch source.
//   - Buttons are synchronized, debounced per bit, and a debounced press
//     (1->0) loads a single local pending slot with sel=button index and
//     data=switches_in. Presses that cannot be accepted are counted in a
//     saturating drop counter.
//   - A two-state FSM (IDLE/WRITE) grants either the host request or the
//     pending slot (round-robin on a tie) and commits one write per 2 cycles.
//
// Ports
//   clk_clk        system clock
//   reset_reset_n  asynchronous active-low reset
//   host_req/sel/data, host_ack   host write handshake (ack = 1-cycle pulse)
//   lock_local     blocks local writes from being granted (slot is kept)
//   buttons_in     raw active-low pushbuttons (asynchronous)
//   switches_in    data source for local writes
//   disp_left, disp_right, led_green, led_red   panel registers
//   last_owner     owner of the most recent commit (0 local, 1 host)
//   drop_cnt       saturating count of dropped local presses
module io_panel_arbiter #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        host_req,
    input  logic [1:0]  host_sel,
    input  logic [31:0] host_data,
    output logic        host_ack,
    input  logic        lock_local,
    input  logic [3:0]  buttons_in,
    input  logic [31:0] switches_in,
    output logic [31:0] disp_left,
    output logic [31:0] disp_right,
    output logic [31:0] led_green,
    output logic [31:0] led_red,
    output logic        last_owner,
    output logic [7:0]  drop_cnt
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

    typedef enum logic {IDLE = 1'b0, WRITE = 1'b1} state_t;

    logic [3:0] press;

    // ------------------------------------------------------------------
    // Per-button synchronizer and debouncer
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            logic [SYNC_STAGES-1:0] sync_q, sync_d;
            logic [CNT_W-1:0]       cnt_q, cnt_d;
            logic                   db_q, db_d;
            logic                   sync_lvl;

            assign sync_lvl = sync_q[SYNC_STAGES-1];

            always_comb begin
                // Shift toward the MSB; the cast drops the oldest sample.
                sync_d = SYNC_STAGES'({sync_q, buttons_in[gi]});
                cnt_d  = '0;
                db_d   = db_q;
                if (sync_lvl != db_q) begin
                    // Accept the new level on the Nth consecutive differing cycle.
                    if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        db_d = sync_lvl;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    sync_q <= '1;
                    cnt_q  <= '0;
                    db_q   <= 1'b1;
                end else begin
                    sync_q <= sync_d;
                    cnt_q  <= cnt_d;
                    db_q   <= db_d;
                end
            end

            // Press event is the cycle in which the debounced level falls.
            assign press[gi] = db_q & ~db_d;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    state_t      state_q, state_d;
    logic        host_ack_q, host_ack_d;
    logic        last_owner_q, last_owner_d;
    logic [7:0]  drop_cnt_q, drop_cnt_d;
    logic        slot_valid_q, slot_valid_d;
    logic [1:0]  slot_sel_q, slot_sel_d;
    logic [31:0] slot_data_q, slot_data_d;
    logic        owner_q, owner_d;
    logic [1:0]  wsel_q, wsel_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] panel_q [4];
    logic [31:0] panel_d [4];

    logic        win_valid;
    logic [1:0]  win_sel;
    logic [2:0]  n_press;
    logic [2:0]  n_drop;
    logic [8:0]  drop_sum;
    logic        loc_cand;

    // Press arbitration: lowest index wins; every other press is a drop,
    // and all presses are drops while the slot is occupied.
    always_comb begin
        win_valid = 1'b0;
        win_sel   = 2'd0;
        n_press   = 3'd0;
        for (int i = 3; i >= 0; i--) begin
            if (press[i]) begin
                win_valid = 1'b1;
                win_sel   = 2'(i);
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_press = n_press + {2'b00, press[i]};
        end
        if (slot_valid_q || !win_valid) begin
            n_drop = n_press;
        end else begin
            n_drop = n_press - 3'd1;
        end
        drop_sum = {1'b0, drop_cnt_q} + {6'd0, n_drop};
    end

    always_comb begin
        state_d      = state_q;
        host_ack_d   = 1'b0;
        last_owner_d = last_owner_q;
        drop_cnt_d   = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
        slot_valid_d = slot_valid_q;
        slot_sel_d   = slot_sel_q;
        slot_data_d  = slot_data_q;
        owner_d      = owner_q;
        wsel_d       = wsel_q;
        wdata_d      = wdata_q;
        for (int i = 0; i < 4; i++) begin
            panel_d[i] = panel_q[i];
        end
        loc_cand = slot_valid_q & ~lock_local;

        case (state_q)
            IDLE: begin
                // Host wins when alone, or on a tie when local owned last.
                if (host_req && (!loc_cand || !last_owner_q)) begin
                    owner_d    = 1'b1;
                    wsel_d     = host_sel;
                    wdata_d    = host_data;
                    host_ack_d = 1'b1;
                    state_d    = WRITE;
                end else if (loc_cand) begin
                    owner_d = 1'b0;
                    wsel_d  = slot_sel_q;
                    wdata_d = slot_data_q;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                panel_d[wsel_q] = wdata_q;
                last_owner_d    = owner_q;
                if (!owner_q) begin
                    slot_valid_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Load only into an empty slot; a clear in this same cycle still
        // sees the slot full, so the press is counted as a drop above.
        if (win_valid && !slot_valid_q) begin
            slot_valid_d = 1'b1;
            slot_sel_d   = win_sel;
            slot_data_d  = switches_in;
        end
    end

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_q      <= IDLE;
            host_ack_q   <= 1'b0;
            last_owner_q <= 1'b0;
            drop_cnt_q   <= 8'd0;
            slot_valid_q <= 1'b0;
            slot_sel_q   <= 2'd0;
            slot_data_q  <= 32'd0;
            owner_q      <= 1'b0;
            wsel_q       <= 2'd0;
            wdata_q      <= 32'd0;
            for (int i = 0; i < 4; i++) begin
                panel_q[i] <= 32'd0;
            end
        end else begin
            state_q      <= state_d;
            host_ack_q   <= host_ack_d;
            last_owner_q <= last_owner_d;
            drop_cnt_q   <= drop_cnt_d;
            slot_valid_q <= slot_valid_d;
            slot_sel_q   <= slot_sel_d;
            slot_data_q  <= slot_data_d;
            owner_q      <= owner_d;
            wsel_q       <= wsel_d;
            wdata_q      <= wdata_d;
            for (int i = 0; i < 4; i++) begin
                panel_q[i] <= panel_d[i];
            end
        end
    end

    assign host_ack   = host_ack_q;
    assign last_owner = last_owner_q;
    assign drop_cnt   = drop_cnt_q;
    assign disp_left  = panel_q[0];
    assign disp_right = panel_q[1];
    assign led_green  = panel_q[2];
    assign led_red    = panel_q[3];

endmodule

// File: tb/tb_io_panel_arbiter.sv
// Testbench for io_panel_arbiter with DEBOUNCE_CYCLES=4, SYNC_STAGES=2.
// Directed scenarios followed by randomized host/local transactions checked
// against a transaction-level model (expected panel contents, last owner,
// drop count).
module tb_io_panel_arbiter;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n;
    logic        host_req;
    logic [1:0]  host_sel;
    logic [31:0] host_data;
    logic        host_ack;
    logic        lock_local;
    logic [3:0]  buttons_in;
    logic [31:0] switches_in;
    logic [31:0] disp_left, disp_right, led_green, led_red;
    logic        last_owner;
    logic [7:0]  drop_cnt;

    io_panel_arbiter #(.DEBOUNCE_CYCLES(4), .SYNC_STAGES(2)) dut (
        .clk_clk      (clk_clk),
        .reset_reset_n(reset_reset_n),
        .host_req     (host_req),
        .host_sel     (host_sel),
        .host_data    (host_data),
        .host_ack     (host_ack),
        .lock_local   (lock_local),
        .buttons_in   (buttons_in),
        .switches_in  (switches_in),
        .disp_left    (disp_left),
        .disp_right   (disp_right),
        .led_green    (led_green),
        .led_red      (led_red),
        .last_owner   (last_owner),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk_clk = ~clk_clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model state
    logic [31:0] exp_panel [4];
    logic        exp_last;
    int          exp_drop;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_panel[i] = 32'd0;
        exp_last = 1'b0;
        exp_drop = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".disp_left"},  disp_left,  exp_panel[0]);
        check({tag, ".disp_right"}, disp_right, exp_panel[1]);
        check({tag, ".led_green"},  led_green,  exp_panel[2]);
        check({tag, ".led_red"},    led_red,    exp_panel[3]);
        check({tag, ".last_owner"}, {31'd0, last_owner}, {31'd0, exp_last});
        check({tag, ".drop_cnt"},   {24'd0, drop_cnt},   32'(exp_drop));
    endtask

    task automatic do_reset();
        @(negedge clk_clk);
        reset_reset_n = 1'b0;
        host_req = 1'b0;
        lock_local = 1'b0;
        buttons_in = 4'hF;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        model_reset();
        @(negedge clk_clk);
    endtask

    // Host write from an idle arbiter; reports cycles from request to ack.
    task automatic host_write(input logic [1:0] sel, input logic [31:0] data, output int lat);
        host_sel  = sel;
        host_data = data;
        host_req  = 1'b1;
        lat = -1;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk_clk);
            if (host_ack) begin
                lat = i;
                break;
            end
        end
        if (lat < 0) check("host_ack_timeout", 32'd0, 32'd1);
        host_req = 1'b0;
        @(negedge clk_clk);
        check("host_ack_pulse", {31'd0, host_ack}, 32'd0);
    endtask

    // Press the buttons in mask simultaneously, hold, release, let settle.
    task automatic press(input logic [3:0] mask, input logic [31:0] sw);
        switches_in = sw;
        buttons_in  = ~mask;
        repeat (10) @(negedge clk_clk);
        buttons_in = 4'hF;
        repeat (10) @(negedge clk_clk);
    endtask

    function automatic int lowest(input logic [3:0] m);
        for (int i = 0; i < 4; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int popcnt(input logic [3:0] m);
        int c = 0;
        for (int i = 0; i < 4; i++) if (m[i]) c++;
        return c;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    initial begin
        int          lat;
        logic [31:0] sw_a, sw_b, d;
        logic [3:0]  m;
        logic [1:0]  s;

        reset_reset_n = 1'b1;
        host_req = 1'b0; host_sel = 2'd0; host_data = 32'd0;
        lock_local = 1'b0; buttons_in = 4'hF; switches_in = 32'd0;
        model_reset();
        #2 reset_reset_n = 1'b0;
        #10;
        check("rst.host_ack", {31'd0, host_ack}, 32'd0);
        check_all("rst");
        @(negedge clk_clk);
        reset_reset_n = 1'b1;
        @(negedge clk_clk);

        // Host-only write
        host_write(2'd2, 32'h0000_00FF, lat);
        check("host.latency", 32'(lat), 32'd1);
        exp_panel[2] = 32'h0000_00FF; exp_last = 1'b1;
        check_all("host_only");
        $display("txn host sel=2 data=000000ff latency=%0d", lat);

        // Local press of button 1
        do_reset();
        press(4'b0010, 32'h1234_5678);
        exp_panel[1] = 32'h1234_5678; exp_last = 1'b0;
        check_all("local_press");
        $display("txn local btn=1 data=12345678");

        // Bounce on button 0 produces no event
        for (int i = 0; i < 10; i++) begin
            buttons_in[0] = ~buttons_in[0];
            repeat (2) @(negedge clk_clk);
        end
        buttons_in = 4'hF;
        repeat (12) @(negedge clk_clk);
        check_all("bounce");
        $display("txn bounce btn=0");

        // Tie after reset: host first, then local
        do_reset();
        lock_local = 1'b1;
        press(4'b0001, 32'hCAFE_0001);
        check_all("tie.pending_locked");
        host_sel = 2'd3; host_data = 32'hBEEF_0003; host_req = 1'b1;
        lock_local = 1'b0;
        @(negedge clk_clk);
        check("tie.host_ack", {31'd0, host_ack}, 32'd1);
        host_req = 1'b0;
        @(negedge clk_clk);
        exp_panel[3] = 32'hBEEF_0003; exp_last = 1'b1;
        check_all("tie.host_commit");
        repeat (2) @(negedge clk_clk);
        exp_panel[0] = 32'hCAFE_0001; exp_last = 1'b0;
        check_all("tie.local_commit");
        $display("txn tie host sel=3 then local btn=0");

        // Lock and drop
        lock_local = 1'b1;
        sw_a = 32'hA5A5_0002; sw_b = 32'h5A5A_0003;
        press(4'b0100, sw_a);
        press(4'b1000, sw_b);
        exp_drop = 1;
        check_all("lock.held");
        lock_local = 1'b0;
        repeat (3) @(negedge clk_clk);
        exp_panel[2] = sw_a; exp_last = 1'b0;
        check_all("lock.released");
        $display("txn lock btn=2 kept, btn=3 dropped");

        // Reset during WRITE: no commit, slot emptied
        lock_local = 1'b1;
        press(4'b1000, 32'h7777_7777);
        host_sel = 2'd0; host_data = 32'h1111_1111; host_req = 1'b1;
        @(negedge clk_clk);
        check("rstw.in_write_ack", {31'd0, host_ack}, 32'd1);
        reset_reset_n = 1'b0;
        #1;
        model_reset();
        check("rstw.host_ack", {31'd0, host_ack}, 32'd0);
        check_all("rstw.during");
        host_req = 1'b0; lock_local = 1'b0;
        repeat (2) @(negedge clk_clk);
        reset_reset_n = 1'b1;
        repeat (8) @(negedge clk_clk);
        check_all("rstw.after");
        $display("txn reset during write");

        // Randomized transactions against the model
        for (int t = 0; t < 16; t++) begin
            case ($urandom_range(0, 2))
                0: begin
                    s = 2'($urandom_range(0, 3));
                    d = $urandom;
                    host_write(s, d, lat);
                    check("rnd.host_latency", 32'(lat), 32'd1);
                    exp_panel[s] = d; exp_last = 1'b1;
                    $display("txn rnd host sel=%0d data=%h", s, d);
                end
                1: begin
                    s = 2'($urandom_range(0, 3));
                    d = $urandom;
                    m = 4'b0001 << s;
                    press(m, d);
                    exp_panel[s] = d; exp_last = 1'b0;
                    $display("txn rnd local btn=%0d data=%h", s, d);
                end
                default: begin
                    m = 4'($urandom_range(1, 15));
                    d = $urandom;
                    press(m, d);
                    exp_panel[lowest(m)] = d; exp_last = 1'b0;
                    exp_drop = sat(exp_drop + popcnt(m) - 1);
                    $display("txn rnd multi mask=%b data=%h", m, d);
                end
            endcase
            check_all("rnd");
        end

        // Saturation of drop_cnt while the slot is held by lock
        lock_local = 1'b1;
        press(4'b0010, 32'hD00D_0001);
        for (int i = 0; i < 64; i++) begin
            press(4'hF, $urandom);
            exp_drop = sat(exp_drop + 4);
        end
        check_all("sat.locked");
        lock_local = 1'b0;
        repeat (3) @(negedge clk_clk);
        exp_panel[1] = 32'hD00D_0001; exp_last = 1'b0;
        check_all("sat.released");
        $display("txn drop saturation drop_cnt=%0d", drop_cnt);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
